fifo_rptr_rd: RTL and testbench
===============================

# fifo_rptr_rd

Read-side controller for the asynchronous FIFO, operating entirely in the read clock domain. It keeps the read pointer, generates the memory read address and a Gray-coded pointer for the write-domain synchronizer, and produces a registered empty flag. It also drains the dual-port memory into a one-entry output register with a valid/ready handshake. It is the consumer counterpart of the FIFO memory write port: it reads entries the write side has stored and retires them by advancing `rptr`.

## Interface
- `DATASIZE`, 32, data word width.
- `ADDRSIZE`, 5, memory address width. FIFO depth is 2^ADDRSIZE. Pointers are ADDRSIZE+1 bits, with the MSB as the wrap bit.

Ports:
- `rclk` in 1: read clock.
- `rrst_n` in 1: reset, asynchronous, active-low.
- `rq2_wptr` in ADDRSIZE+1: Gray write pointer, already two-flop synchronized into `rclk`.
- `rmem_data` in DATASIZE: memory read data. It is a combinational function of `raddr`.
- `raddr` out ADDRSIZE: memory read address.
- `rptr` out ADDRSIZE+1: registered Gray read pointer, sent to the write-domain synchronizer.
- `rempty` out 1: registered empty flag.
- `rdata` out DATASIZE: output data register.
- `rvalid` out 1: `rdata` holds an unconsumed word.
- `rready` in 1: the consumer accepts `rdata` this cycle.
- `rlevel` out ADDRSIZE+1: memory occupancy. Present only with `FIFO_RD_LEVEL_EN`.

## Operation
Internal binary read pointer `rbin`, ADDRSIZE+1 bits:
- `raddr` = `rbin[ADDRSIZE-1:0]`.
- `rptr` = registered Gray(`rbin`).

Pop rule:
- `pop` = `!rempty && (!rvalid || rready)`.
- On `pop`:
  - `rdata <= rmem_data`.
  - `rvalid <= 1`.
  - `rbin <= rbin + 1`.
  - `rptr <= Gray(rbin + 1)`.

Handshake:
- `rvalid && rready && rempty`: `rvalid <= 0`, and `rdata` holds its old value.
- `rvalid && !rready`: `rdata`, `rvalid`, `rbin` and `raddr` all hold.
- `rvalid` never drops without a transfer, except on reset.

Empty flag:
- `rempty <= (Gray(rbin_next) == rq2_wptr)`.
- `rbin_next` is `rbin + pop`.

Wrap-around:
- `rbin` wraps modulo 2^(ADDRSIZE+1).
- `raddr` wraps from 2^ADDRSIZE−1 to 0.
- The `rptr` MSB toggles once every 2^ADDRSIZE pops.
- Consecutive `rptr` values differ in exactly one bit.

Reset values:
- `rbin` = 0, `rptr` = 0, `raddr` = 0.
- `rempty` = 1, `rvalid` = 0, `rdata` = 0.
- `rlevel` = 0.

Reset asserted mid-stream clears all state immediately. Any word held in `rdata` is discarded.

## Timing
- A new `rq2_wptr` value is reflected in `rempty` at the next `rclk` edge.
- Latency from `rempty` falling to `rvalid` rising is one `rclk` edge, because the pop occurs on the first edge with `!rempty`.
- With `rready` held high and the FIFO non-empty, throughput is one word per cycle.
- `rempty` is pessimistic: it asserts on the same edge as the final pop. Write-side progress is seen only after the external synchronizer delay.
- Data is captured on the same edge that advances `rptr`. The write side cannot reuse the slot before that edge.

## Configuration
- `FIFO_RD_LEVEL_EN` defined:
  - `rlevel` port exists.
  - It is registered as `rlevel <= bin(rq2_wptr) − rbin_next`, modulo 2^(ADDRSIZE+1).
  - Range is 0..2^ADDRSIZE. The word held in `rdata` is not counted.
  - Gray-to-binary conversion is an XOR prefix.
- `FIFO_RD_LEVEL_EN` undefined:
  - Port and logic are absent.
  - All other behaviour is identical.

## Test plan
- **Reset:** hold `rrst_n` = 0 with arbitrary inputs -> `rempty` = 1, `rvalid` = 0, `rptr` = 0, `raddr` = 0, `rdata` = 0.
- **Single word:** mem[0] = 0xA5A50001; step `rq2_wptr` 0 -> Gray(1) = 0x01 -> next edge `rempty` = 0; following edge `rvalid` = 1, `rdata` = 0xA5A50001, `rptr` = 0x01, `rempty` = 1.
- **Backpressure:** mem[0..2] = 0x10, 0x11, 0x12; `rq2_wptr` = Gray(3); `rready` = 0 for 5 cycles -> `rdata` = 0x10 stable, `raddr` = 1. Then `rready` = 1 -> transfers 0x10, 0x11, 0x12 on consecutive cycles, then `rvalid` = 0.
- **Wrap:** stream 70 words with `rready` = 1 and the writer keeping the FIFO non-empty -> data in order, no loss or duplication; `raddr` goes 31 -> 0; `rptr` MSB toggles after pops 32 and 64; every `rptr` step changes exactly one bit.
- **Reset mid-stream:** assert `rrst_n` low while `rvalid` = 1 and `rbin` = 7 -> outputs return to reset values without waiting for a clock edge.
- **Level (macro on):** `rq2_wptr` = Gray(20), `rbin` = 0, `rready` = 0 -> after the first pop `rlevel` = 19, holding at 19. Then `rready` = 1 -> `rlevel` decrements by 1 per cycle to 0.

Source files
------------

// File: rtl/fifo_rptr_rd_if.sv
// Consumer-side handshake of the asynchronous FIFO read controller:
// output data register, valid flag and the consumer's ready.
interface fifo_rptr_rd_if #(
    parameter int unsigned DATASIZE = 32
);
    logic [DATASIZE-1:0] rdata;
    logic                rvalid;
    logic                rready;

    // Controller side drives data/valid, consumer drives ready.
    modport master (output rdata, output rvalid, input rready);
    modport slave  (input rdata, input rvalid, output rready);
endinterface

// File: rtl/fifo_rptr_rd.sv
// Read-side controller of the asynchronous FIFO (read clock domain).
// Keeps the binary/Gray read pointer, a registered empty flag, and drains
// the dual-port memory into a one-entry valid/ready output register.
// Optional build macro FIFO_RD_LEVEL_EN adds the registered rlevel port
// (memory occupancy, excluding the word held in rdata).
module fifo_rptr_rd #(
    parameter int unsigned DATASIZE = 32,
    parameter int unsigned ADDRSIZE = 5
) (
    input  logic                rclk,
    input  logic                rrst_n,
    input  logic [ADDRSIZE:0]   rq2_wptr,
    input  logic [DATASIZE-1:0] rmem_data,
    output logic [ADDRSIZE-1:0] raddr,
    output logic [ADDRSIZE:0]   rptr,
    output logic                rempty,
    fifo_rptr_rd_if.master      rd
`ifdef FIFO_RD_LEVEL_EN
    ,
    output logic [ADDRSIZE:0]   rlevel
`endif
);

    localparam int unsigned PW = ADDRSIZE + 1;

    logic [PW-1:0] rbin;
    logic [PW-1:0] rbin_next_c;
    logic [PW-1:0] rgray_next_c;
    logic          pop_c;

    // Pop whenever memory holds a word and the output register is free or draining.
    always_comb begin
        pop_c        = 1'b0;
        rbin_next_c  = rbin;
        rgray_next_c = '0;
        pop_c        = !rempty && (!rd.rvalid || rd.rready);
        rbin_next_c  = rbin + PW'(pop_c);
        rgray_next_c = (rbin_next_c >> 1) ^ rbin_next_c;
    end

    // Memory address is the low bits of the binary pointer.
    assign raddr = rbin[ADDRSIZE-1:0];

    // Pointer and pessimistic empty flag; empty is evaluated against the post-pop pointer.
    always_ff @(posedge rclk or negedge rrst_n) begin
        if (!rrst_n) begin
            rbin   <= '0;
            rptr   <= '0;
            rempty <= 1'b1;
        end else begin
            rbin   <= rbin_next_c;
            rptr   <= rgray_next_c;
            rempty <= (rgray_next_c == rq2_wptr);
        end
    end

    // Output register: capture on pop, release only after a completed transfer.
    always_ff @(posedge rclk or negedge rrst_n) begin
        if (!rrst_n) begin
            rd.rdata  <= '0;
            rd.rvalid <= 1'b0;
        end else if (pop_c) begin
            rd.rdata  <= rmem_data;
            rd.rvalid <= 1'b1;
        end else if (rd.rvalid && rd.rready) begin
            rd.rvalid <= 1'b0;
        end
    end

`ifdef FIFO_RD_LEVEL_EN
    // Gray to binary: each binary bit is the XOR of all Gray bits at or above it.
    function automatic logic [PW-1:0] gray2bin(input logic [PW-1:0] g);
        logic [PW-1:0] b;
        b = g;
        for (int unsigned k = 1; k < PW; k++) begin
            b = b ^ (g >> k);
        end
        return b;
    endfunction

    // Occupancy of the memory after this cycle's pop, modulo pointer range.
    always_ff @(posedge rclk or negedge rrst_n) begin
        if (!rrst_n) begin
            rlevel <= '0;
        end else begin
            rlevel <= gray2bin(rq2_wptr) - rbin_next_c;
        end
    end
`endif

endmodule

// File: tb/tb_fifo_rptr_rd.sv
// Self-checking bench for fifo_rptr_rd: cycle vector table for reset,
// single-word and backpressure cases, then scoreboarded streaming over the
// pointer wrap, asynchronous mid-stream reset and (optionally) rlevel.
module tb_fifo_rptr_rd;

    localparam int unsigned DW = 32;
    localparam int unsigned AW = 5;

    logic          clk;
    logic          rrst_n;
    logic [AW:0]   rq2_wptr;
    logic [DW-1:0] rmem_data;
    logic [AW-1:0] raddr;
    logic [AW:0]   rptr;
    logic          rempty;
`ifdef FIFO_RD_LEVEL_EN
    logic [AW:0]   rlevel;
`endif

    logic [DW-1:0] mem [32];

    fifo_rptr_rd_if #(.DATASIZE(DW)) rd_if ();

    fifo_rptr_rd #(.DATASIZE(DW), .ADDRSIZE(AW)) dut (
        .rclk      (clk),
        .rrst_n    (rrst_n),
        .rq2_wptr  (rq2_wptr),
        .rmem_data (rmem_data),
        .raddr     (raddr),
        .rptr      (rptr),
        .rempty    (rempty),
        .rd        (rd_if)
`ifdef FIFO_RD_LEVEL_EN
        ,
        .rlevel    (rlevel)
`endif
    );

    // Memory read port is combinational on the read address.
    assign rmem_data = mem[raddr];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic          rst_n;
        logic          mw;
        logic [4:0]    ma;
        logic [31:0]   md;
        logic [5:0]    wptr;
        logic          rready;
        logic          e_empty;
        logic          e_valid;
        logic [31:0]   e_data;
        logic [5:0]    e_ptr;
        logic [4:0]    e_addr;
    } vec_t;

    vec_t        tbl [$];
    logic [31:0] sbq [$];
    int          n_vec;
    int          n_bad;

    function automatic logic [5:0] gray(input logic [5:0] b);
        return b ^ (b >> 1);
    endfunction

    function automatic vec_t mk(input logic rst_n, input logic mw, input logic [4:0] ma,
                                input logic [31:0] md, input logic [5:0] wptr, input logic rdy,
                                input logic ee, input logic ev, input logic [31:0] ed,
                                input logic [5:0] ep, input logic [4:0] ea);
        vec_t v;
        v.rst_n = rst_n; v.mw = mw; v.ma = ma; v.md = md; v.wptr = wptr; v.rready = rdy;
        v.e_empty = ee; v.e_valid = ev; v.e_data = ed; v.e_ptr = ep; v.e_addr = ea;
        return v;
    endfunction

    task automatic chk(input string name, input logic ok, input string detail);
        n_vec++;
        if (!ok) begin
            n_bad++;
            $display("FAIL %s: %s", name, detail);
        end
    endtask

    task automatic do_reset();
        rrst_n      = 1'b0;
        rd_if.rready = 1'b0;
        rq2_wptr    = '0;
        @(posedge clk);
        #1;
        rrst_n = 1'b1;
    endtask

    task automatic chk_idle(input string name);
        chk(name, rempty === 1'b1 && rd_if.rvalid === 1'b0 && rptr === 6'd0 &&
                  raddr === 5'd0 && rd_if.rdata === 32'd0,
            $sformatf("got empty=%b valid=%b ptr=%h addr=%h data=%h, want 1 0 00 00 00000000",
                      rempty, rd_if.rvalid, rptr, raddr, rd_if.rdata));
    endtask

    initial begin
        int wbin;
        int xfers;
        int popped;
        int msb_toggles;
        logic [5:0] prev_ptr;
        logic [31:0] exp_d;
        bit found;

        n_vec = 0;
        n_bad = 0;
        for (int i = 0; i < 32; i++) mem[i] = '0;
        rrst_n       = 1'b0;
        rq2_wptr     = '0;
        rd_if.rready = 1'b0;

        // rst mw ma md wptr rdy | empty valid data ptr addr
        tbl.push_back(mk(0, 0, 0, 0,            6'd5, 1, 1, 0, 0,            6'd0, 5'd0));
        tbl.push_back(mk(1, 1, 0, 32'hA5A50001, 6'd0, 1, 1, 0, 0,            6'd0, 5'd0));
        tbl.push_back(mk(1, 0, 0, 0,            6'd1, 1, 0, 0, 0,            6'd0, 5'd0));
        tbl.push_back(mk(1, 0, 0, 0,            6'd1, 1, 1, 1, 32'hA5A50001, 6'd1, 5'd1));
        tbl.push_back(mk(1, 0, 0, 0,            6'd1, 1, 1, 0, 32'hA5A50001, 6'd1, 5'd1));
        tbl.push_back(mk(0, 0, 0, 0,            6'd1, 1, 1, 0, 0,            6'd0, 5'd0));
        tbl.push_back(mk(1, 1, 0, 32'h10,       6'd0, 0, 1, 0, 0,            6'd0, 5'd0));
        tbl.push_back(mk(1, 1, 1, 32'h11,       6'd2, 0, 0, 0, 0,            6'd0, 5'd0));
        tbl.push_back(mk(1, 1, 2, 32'h12,       6'd2, 0, 0, 1, 32'h10,       6'd1, 5'd1));
        for (int i = 0; i < 5; i++)
            tbl.push_back(mk(1, 0, 0, 0,        6'd2, 0, 0, 1, 32'h10,       6'd1, 5'd1));
        tbl.push_back(mk(1, 0, 0, 0,            6'd2, 1, 0, 1, 32'h11,       6'd3, 5'd2));
        tbl.push_back(mk(1, 0, 0, 0,            6'd2, 1, 1, 1, 32'h12,       6'd2, 5'd3));
        tbl.push_back(mk(1, 0, 0, 0,            6'd2, 1, 1, 0, 32'h12,       6'd2, 5'd3));

        #2;
        foreach (tbl[i]) begin
            rrst_n       = tbl[i].rst_n;
            rq2_wptr     = tbl[i].wptr;
            rd_if.rready = tbl[i].rready;
            if (tbl[i].mw) mem[tbl[i].ma] = tbl[i].md;
            @(posedge clk);
            #1;
            chk($sformatf("vec%0d", i),
                rempty === tbl[i].e_empty && rd_if.rvalid === tbl[i].e_valid &&
                rd_if.rdata === tbl[i].e_data && rptr === tbl[i].e_ptr && raddr === tbl[i].e_addr,
                $sformatf("got empty=%b valid=%b data=%h ptr=%h addr=%h, want %b %b %h %h %h",
                          rempty, rd_if.rvalid, rd_if.rdata, rptr, raddr,
                          tbl[i].e_empty, tbl[i].e_valid, tbl[i].e_data, tbl[i].e_ptr, tbl[i].e_addr));
        end

        // Streaming across the pointer wrap with a writer staying a few words ahead.
        do_reset();
        wbin = 0; xfers = 0; msb_toggles = 0; prev_ptr = '0;
        sbq.delete();
        rd_if.rready = 1'b1;
        for (int cyc = 0; cyc < 600 && xfers < 70; cyc++) begin
            popped = xfers + int'(rd_if.rvalid);
            chk("wrap_ptr", rptr === gray(6'(popped)) && raddr === 5'(popped),
                $sformatf("got ptr=%h addr=%h, want %h %h", rptr, raddr, gray(6'(popped)), 5'(popped)));
            if (rptr !== prev_ptr) begin
                chk("wrap_onebit", $countones(rptr ^ prev_ptr) == 1,
                    $sformatf("got step %h->%h, want one bit change", prev_ptr, rptr));
                if (rptr[5] !== prev_ptr[5]) msb_toggles++;
                prev_ptr = rptr;
            end
            if (rd_if.rvalid) begin
                if (sbq.size() == 0) begin
                    chk("wrap_extra", 1'b0, $sformatf("got data=%h, want no word", rd_if.rdata));
                end else begin
                    exp_d = sbq.pop_front();
                    chk("wrap_data", rd_if.rdata === exp_d,
                        $sformatf("got %h, want %h", rd_if.rdata, exp_d));
                end
                xfers++;
            end
            if (wbin < 70 && (wbin - xfers) < 8) begin
                mem[wbin % 32] = 32'hC000_0000 + 32'(wbin);
                sbq.push_back(32'hC000_0000 + 32'(wbin));
                wbin++;
                rq2_wptr = gray(6'(wbin));
            end
            @(posedge clk);
            #1;
        end
        chk("wrap_count", xfers == 70, $sformatf("got %0d transfers, want 70", xfers));
        chk("wrap_msb", msb_toggles == 2, $sformatf("got %0d MSB toggles, want 2", msb_toggles));
        chk("wrap_end", rempty === 1'b1 && rd_if.rvalid === 1'b0 && sbq.size() == 0,
            $sformatf("got empty=%b valid=%b left=%0d, want 1 0 0", rempty, rd_if.rvalid, sbq.size()));

        // Asynchronous reset while a word is held and rbin is 7.
        do_reset();
        for (int i = 0; i < 10; i++) mem[i] = 32'h700 + 32'(i);
        rq2_wptr     = gray(6'd10);
        rd_if.rready = 1'b1;
        found = 1'b0;
        for (int cyc = 0; cyc < 30 && !found; cyc++) begin
            @(posedge clk);
            #1;
            if (rptr === gray(6'd7)) found = 1'b1;
        end
        chk("mid_reach", found && rd_if.rvalid === 1'b1 && rd_if.rdata === 32'h706,
            $sformatf("got found=%b valid=%b data=%h, want 1 1 00000706", found, rd_if.rvalid, rd_if.rdata));
        #2;
        rrst_n = 1'b0;
        #1;
        chk_idle("mid_reset");
        @(posedge clk);
        #1;
        rrst_n = 1'b1;

`ifdef FIFO_RD_LEVEL_EN
        // Level reporting: hold with backpressure, then drain.
        do_reset();
        chk("lvl_reset", rlevel === 6'd0, $sformatf("got %0d, want 0", rlevel));
        sbq.delete();
        for (int i = 0; i < 20; i++) begin
            mem[i] = 32'h5000 + 32'(i);
            sbq.push_back(32'h5000 + 32'(i));
        end
        rq2_wptr = gray(6'd20);
        xfers = 0;
        for (int cyc = 0; cyc < 5; cyc++) begin
            @(posedge clk);
            #1;
            popped = int'(rd_if.rvalid);
            chk("lvl_hold", rlevel === 6'(20 - popped),
                $sformatf("got %0d, want %0d", rlevel, 20 - popped));
        end
        chk("lvl_19", rlevel === 6'd19, $sformatf("got %0d, want 19", rlevel));
        rd_if.rready = 1'b1;
        for (int cyc = 0; cyc < 60 && xfers < 20; cyc++) begin
            popped = xfers + int'(rd_if.rvalid);
            chk("lvl_drain", rlevel === 6'(20 - popped),
                $sformatf("got %0d, want %0d", rlevel, 20 - popped));
            if (rd_if.rvalid) begin
                exp_d = (sbq.size() != 0) ? sbq.pop_front() : 32'hDEAD_BEEF;
                chk("lvl_data", rd_if.rdata === exp_d, $sformatf("got %h, want %h", rd_if.rdata, exp_d));
                xfers++;
            end
            @(posedge clk);
            #1;
        end
        chk("lvl_end", xfers == 20 && rlevel === 6'd0,
            $sformatf("got xfers=%0d level=%0d, want 20 0", xfers, rlevel));
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
